dram_chip: RTL and testbench

//  Cycle-level emulation model of one DDR4 DRAM device (x4 default) for the memory-emulation platform.

---
 rtl/dram_pkg.sv | 56 +++++
 rtl/dram_bank_fsm.sv | 97 +++++++++
 rtl/dram_chip.sv | 131 +++++++++++++
 tb/tb_dram_chip.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// Shared definitions for the DDR4 device emulation model: command bit
// positions, per-bank state encoding and timer sizing.
package dram_pkg;

  // Width of the one-hot command vector presented to the device.
  localparam int CMD_WIDTH = 19;

  // Bit position of each command inside the command vector.
  localparam int CMD_ACT  = 18;
  localparam int CMD_BST  = 17;
  localparam int CMD_CFG  = 16;
  localparam int CMD_CKEH = 15;
  localparam int CMD_CKEL = 14;
  localparam int CMD_DPD  = 13;
  localparam int CMD_DPDX = 12;
  localparam int CMD_MRR  = 11;
  localparam int CMD_MRW  = 10;
  localparam int CMD_PD   = 9;
  localparam int CMD_PDX  = 8;
  localparam int CMD_PR   = 7;
  localparam int CMD_PRA  = 6;
  localparam int CMD_RD   = 5;
  localparam int CMD_RDA  = 4;
  localparam int CMD_REF  = 3;
  localparam int CMD_SRF  = 2;
  localparam int CMD_WR   = 1;
  localparam int CMD_WRA  = 0;

  // Commands that are accepted on the bus but have no effect in this model.
  localparam logic [CMD_WIDTH-1:0] NOOP_MASK =
      (CMD_WIDTH'(1) << CMD_BST)  | (CMD_WIDTH'(1) << CMD_CFG)  |
      (CMD_WIDTH'(1) << CMD_CKEH) | (CMD_WIDTH'(1) << CMD_CKEL) |
      (CMD_WIDTH'(1) << CMD_DPD)  | (CMD_WIDTH'(1) << CMD_DPDX) |
      (CMD_WIDTH'(1) << CMD_MRR)  | (CMD_WIDTH'(1) << CMD_MRW)  |
      (CMD_WIDTH'(1) << CMD_PD)   | (CMD_WIDTH'(1) << CMD_PDX)  |
      (CMD_WIDTH'(1) << CMD_REF)  | (CMD_WIDTH'(1) << CMD_SRF);

  // Width of the per-bank timing counter; large enough for any tRCD/tRP used.
  localparam int TIMER_WIDTH = 8;

  // Life cycle of a single bank.
  typedef enum logic [2:0] {
    BANK_IDLE,
    BANK_ACTIVATING,
    BANK_ACTIVE,
    BANK_READING,
    BANK_WRITING,
    BANK_PRECHARGING
  } bank_state_t;

  // A bank accepts column commands (RD/WR) only while a row is open.
  function automatic logic bank_is_open(bank_state_t s);
    return (s == BANK_ACTIVE) || (s == BANK_READING) || (s == BANK_WRITING);
  endfunction

endpackage

// File: rtl/dram_bank_fsm.sv
// One DRAM bank: row-open/close state machine with its tRCD/tRP countdown.
// Inputs are already decoded and addressed to this bank by the device top.
module dram_bank_fsm
  import dram_pkg::*;
#(
  parameter int T_RCD = 4,
  parameter int T_RP  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic halt,
  input  logic act,
  input  logic pre,
  input  logic rd,
  input  logic wr,
  input  logic auto_pre,
  output logic col_open
);

  localparam logic [TIMER_WIDTH-1:0] RCD_LOAD = TIMER_WIDTH'(T_RCD - 1);
  localparam logic [TIMER_WIDTH-1:0] RP_LOAD  = TIMER_WIDTH'(T_RP - 1);

  bank_state_t             state_q, state_d;
  logic [TIMER_WIDTH-1:0]  timer_q, timer_d;
  logic                    auto_q, auto_d;

  assign col_open = bank_is_open(state_q);

  // Next-state logic: halt holds everything, otherwise follow the bank protocol.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    auto_d  = auto_q;
    if (!halt) begin
      case (state_q)
        BANK_IDLE: begin
          if (act) begin
            state_d = BANK_ACTIVATING;
            timer_d = RCD_LOAD;
          end
        end
        BANK_ACTIVATING: begin
          if (timer_q == '0) begin
            state_d = BANK_ACTIVE;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        BANK_ACTIVE, BANK_READING, BANK_WRITING: begin
          if (pre) begin
            state_d = BANK_PRECHARGING;
            timer_d = RP_LOAD;
            auto_d  = 1'b0;
          end else if (rd) begin
            state_d = BANK_READING;
            auto_d  = auto_pre;
          end else if (wr) begin
            state_d = BANK_WRITING;
            auto_d  = auto_pre;
          end else if (auto_q) begin
            state_d = BANK_PRECHARGING;
            timer_d = RP_LOAD;
            auto_d  = 1'b0;
          end else begin
            state_d = BANK_ACTIVE;
          end
        end
        BANK_PRECHARGING: begin
          if (timer_q == '0) begin
            state_d = BANK_IDLE;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        default: begin
          state_d = BANK_IDLE;
          timer_d = '0;
          auto_d  = 1'b0;
        end
      endcase
    end
  end

  // State register with synchronous reset back to an idle, precharged bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BANK_IDLE;
      timer_q <= '0;
      auto_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      auto_q  <= auto_d;
    end
  end

endmodule

// File: rtl/dram_chip.sv
// Cycle-level model of one DDR4 device: command decode, one state machine per
// bank, a reduced-depth storage array and the bidirectional DQ/DQS read path.
module dram_chip
  import dram_pkg::*;
#(
  parameter int ADDRWIDTH     = 17,
  parameter int BANKGROUPS    = 2,
  parameter int BANKSPERGROUP = 2,
  parameter int DEVICE_WIDTH  = 4,
  parameter int ROWS          = 2**ADDRWIDTH,
  parameter int COLS          = 1024,
  parameter int BL            = 8,
  parameter int MEMROWS       = 4,
  parameter int T_RCD         = 4,
  parameter int T_RP          = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               halt,
  input  logic [CMD_WIDTH-1:0]               commands,
  input  logic [$clog2(BANKGROUPS):0]        bg,
  input  logic [$clog2(BANKSPERGROUP):0]     ba,
  inout  wire  [DEVICE_WIDTH-1:0]            dq,
  inout  wire                                dqs_c,
  inout  wire                                dqs_t,
  input  logic [ADDRWIDTH-1:0]               row,
  input  logic [$clog2(COLS)-1:0]            column
);

  // Bank groups, banks per group, MEMROWS and COLS are assumed powers of two
  // (at least 2 each), so the stored location is a plain bit concatenation.
  localparam int BG_BITS       = $clog2(BANKGROUPS);
  localparam int BA_BITS       = $clog2(BANKSPERGROUP);
  localparam int BANK_BITS     = BG_BITS + BA_BITS;
  localparam int NUM_BANKS     = 2**BANK_BITS;
  localparam int COL_BITS      = $clog2(COLS);
  localparam int MROW_BITS     = $clog2(MEMROWS);
  localparam int MEM_ADDR_BITS = BANK_BITS + MROW_BITS + COL_BITS;
  localparam int MEM_DEPTH     = 2**MEM_ADDR_BITS;

  // ROWS and BL describe the device but do not change this model's datapath.
  localparam int unused_info_params = ROWS + BL;

  logic                      act_cmd;
  logic                      pre_cmd;
  logic                      pre_all;
  logic                      rd_cmd;
  logic                      wr_cmd;
  logic                      auto_pre;
  logic [BANK_BITS-1:0]      bank_sel;
  logic [NUM_BANKS-1:0]      col_open;
  logic                      sel_open;
  logic                      rd_accept;
  logic                      wr_accept;
  logic [MEM_ADDR_BITS-1:0]  mem_addr;
  logic [DEVICE_WIDTH-1:0]   mem [MEM_DEPTH];
  logic                      rd_valid;
  logic [DEVICE_WIDTH-1:0]   rd_data;
  logic                      unused_inputs;

  assign bank_sel = {bg[BG_BITS-1:0], ba[BA_BITS-1:0]};
  assign mem_addr = {bank_sel, row[MROW_BITS-1:0], column};
  assign sel_open = col_open[bank_sel];

  assign unused_inputs = ^{commands & NOOP_MASK, bg[BG_BITS], ba[BA_BITS],
                           row[ADDRWIDTH-1:MROW_BITS]};

  // Command decode: at most one command class acts per cycle, ACT wins over
  // precharge, precharge over reads, reads over writes.
  always_comb begin
    act_cmd  = commands[CMD_ACT];
    pre_all  = commands[CMD_PRA];
    pre_cmd  = !act_cmd && (commands[CMD_PR] || commands[CMD_PRA]);
    rd_cmd   = !act_cmd && !pre_cmd && (commands[CMD_RD] || commands[CMD_RDA]);
    wr_cmd   = !act_cmd && !pre_cmd && !rd_cmd &&
               (commands[CMD_WR] || commands[CMD_WRA]);
    auto_pre = rd_cmd ? commands[CMD_RDA] : commands[CMD_WRA];
  end

  // A column command only reaches the array if the addressed bank has a row open.
  assign rd_accept = rd_cmd && sel_open;
  assign wr_accept = wr_cmd && sel_open && !halt && !rst;

  genvar b;
  generate
    for (b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic hit;
      assign hit = (bank_sel == BANK_BITS'(b));

      dram_bank_fsm #(
        .T_RCD (T_RCD),
        .T_RP  (T_RP)
      ) u_bank (
        .clk      (clk),
        .rst      (rst),
        .halt     (halt),
        .act      (act_cmd && hit),
        .pre      (pre_cmd && (pre_all || hit)),
        .rd       (rd_cmd && hit),
        .wr       (wr_cmd && hit),
        .auto_pre (auto_pre),
        .col_open (col_open[b])
      );
    end
  endgenerate

  // Storage array: captures the DQ bus on every accepted write; never reset.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[mem_addr] <= dq;
    end
  end

  // Read register: one beat per accepted read, presented on DQ the next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (!halt) begin
      rd_valid <= rd_accept;
      if (rd_accept) begin
        rd_data <= mem[mem_addr];
      end
    end
  end

  assign dq    = rd_valid ? rd_data : {DEVICE_WIDTH{1'bz}};
  assign dqs_t = rd_valid ? 1'b1 : 1'bz;
  assign dqs_c = rd_valid ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_dram_chip.sv
// Self-checking bench for dram_chip: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// timestamp-based behavioural model of the banks and a sparse memory.
module tb_dram_chip;
  import dram_pkg::*;

  localparam int T_RCD = 4;
  localparam int T_RP  = 4;
  localparam int NB    = 4;

  logic        clk;
  logic        rst;
  logic        halt;
  logic [18:0] commands;
  logic [1:0]  bg;
  logic [1:0]  ba;
  logic [16:0] row;
  logic [9:0]  column;
  wire  [3:0]  dq;
  wire         dqs_c;
  wire         dqs_t;

  logic        tb_dq_en;
  logic [3:0]  tb_dq;

  int checks = 0;
  int errors = 0;

  assign dq = tb_dq_en ? tb_dq : 4'bz;

  dram_chip dut (
    .clk      (clk),
    .rst      (rst),
    .halt     (halt),
    .commands (commands),
    .bg       (bg),
    .ba       (ba),
    .dq       (dq),
    .dqs_c    (dqs_c),
    .dqs_t    (dqs_t),
    .row      (row),
    .column   (column)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  // Each bank remembers whether a row was last opened or closed and on which
  // unhalted cycle ("tick"); its status follows from elapsed ticks.
  bit          m_open [NB];
  int          m_ev   [NB];
  bit          m_auto [NB];
  logic [3:0]  m_mem  [int];
  int          tick = 0;
  bit          model_ready = 0;
  bit          exp_drive = 0;
  bit          exp_known = 0;
  logic [3:0]  exp_dq = 4'h0;

  bit          mc_act, mc_pre, mc_rd, mc_wr, mc_nd, mc_nk;
  int          mc_bank, mc_key, mc_st;
  logic [3:0]  mc_nq;

  // 0 idle, 1 opening, 2 open, 3 closing
  function automatic int bank_status(int i);
    if (m_open[i]) return (tick >= m_ev[i] + T_RCD + 1) ? 2 : 1;
    return (tick >= m_ev[i] + T_RP + 1) ? 0 : 3;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NB; i++) begin
        m_open[i] = 1'b0;
        m_ev[i]   = tick - 100;
        m_auto[i] = 1'b0;
      end
      exp_drive   = 1'b0;
      model_ready = 1'b1;
    end else if (!halt) begin
      mc_act  = commands[CMD_ACT];
      mc_pre  = !mc_act && (commands[CMD_PR] || commands[CMD_PRA]);
      mc_rd   = !mc_act && !mc_pre && (commands[CMD_RD] || commands[CMD_RDA]);
      mc_wr   = !mc_act && !mc_pre && !mc_rd && (commands[CMD_WR] || commands[CMD_WRA]);
      mc_bank = int'(bg[0]) * 2 + int'(ba[0]);
      mc_key  = (mc_bank * 4 + int'(row % 4)) * 1024 + int'(column);
      mc_nd   = 1'b0;
      mc_nk   = 1'b0;
      mc_nq   = 4'h0;
      for (int i = 0; i < NB; i++) begin
        mc_st = bank_status(i);
        if (mc_st == 0 && mc_act && i == mc_bank) begin
          m_open[i] = 1'b1;
          m_ev[i]   = tick;
        end else if (mc_st == 2) begin
          if (mc_pre && (commands[CMD_PRA] || i == mc_bank)) begin
            m_open[i] = 1'b0;
            m_ev[i]   = tick;
            m_auto[i] = 1'b0;
          end else if (mc_rd && i == mc_bank) begin
            mc_nd     = 1'b1;
            mc_nk     = m_mem.exists(mc_key);
            if (mc_nk) mc_nq = m_mem[mc_key];
            m_auto[i] = commands[CMD_RDA];
          end else if (mc_wr && i == mc_bank) begin
            m_mem[mc_key] = tb_dq;
            m_auto[i]     = commands[CMD_WRA];
          end else if (m_auto[i]) begin
            m_open[i] = 1'b0;
            m_ev[i]   = tick;
            m_auto[i] = 1'b0;
          end
        end
      end
      exp_drive = mc_nd;
      if (mc_nd) begin
        exp_known = mc_nk;
        exp_dq    = mc_nq;
      end
      tick++;
    end
  end

  // ---------------- checking ----------------
  task automatic checkOutput(input bit exp_drv, input bit chk_data,
                             input logic [3:0] exp_d, input string name);
    checks++;
    if (exp_drv) begin
      if (dqs_t !== 1'b1 || dqs_c !== 1'b0 || (chk_data && dq !== exp_d)) begin
        errors++;
        $display("[TB] FAIL %s at %0t: dq=%h dqs_t=%b dqs_c=%b, required dq=%h dqs_t=1 dqs_c=0",
                 name, $time, dq, dqs_t, dqs_c, exp_d);
      end
    end else if (dqs_t === 1'b1) begin
      errors++;
      $display("[TB] FAIL %s at %0t: dqs_t=%b dq=%h, required bus released (Z)",
               name, $time, dqs_t, dq);
    end
  endtask

  // Every cycle after the first reset, the bus must match the model.
  always @(negedge clk) begin
    if (model_ready) checkOutput(exp_drive, exp_known, exp_dq, "cycle_vs_model");
  end

  // ---------------- stimulus ----------------
  function automatic logic [18:0] cmd(input int idx);
    logic [18:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  task automatic applyStimulus(input bit r, input bit h, input logic [18:0] c,
                               input int bank, input int rw, input int col,
                               input bit den, input logic [3:0] d);
    rst      = r;
    halt     = h;
    commands = c;
    bg       = 2'(bank / 2);
    ba       = 2'(bank % 2);
    row      = 17'(rw);
    column   = 10'(col);
    tb_dq_en = den;
    tb_dq    = d;
    @(posedge clk);
    #1;
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, 0, 0, 0, 0, 4'h0);
  endtask

  int          wcols [6] = '{1, 4, 7, 0, 3, 6};
  logic [3:0]  wvals [6] = '{4'd2, 4'd5, 4'd8, 4'd1, 4'd4, 4'd7};

  initial begin
    logic [18:0] c;
    bit          r, h, den;
    int          pick;

    $display("[TB] start");
    applyStimulus(1, 0, '0, 0, 0, 0, 0, 4'h0);
    checkOutput(0, 0, 4'h0, "reset_released");

    // Bank0 open timing: reads during the tRCD window are ignored.
    applyStimulus(0, 0, cmd(CMD_ACT), 0, 1, 0, 0, 4'h0);
    checkOutput(0, 0, 4'h0, "act_no_drive");
    nop(3);
    applyStimulus(0, 0, cmd(CMD_RD), 0, 1, 0, 0, 4'h0);
    checkOutput(0, 0, 4'h0, "rd_while_activating");
    applyStimulus(0, 0, cmd(CMD_RD), 0, 1, 0, 0, 4'h0);
    checkOutput(1, 0, 4'h0, "rd_after_trcd_drives");
    nop(1);
    checkOutput(0, 0, 4'h0, "burst_end_release");

    // Halt during activation of bank2 delays it by the halted cycles.
    applyStimulus(0, 0, cmd(CMD_ACT), 2, 0, 0, 0, 4'h0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, '0, 0, 0, 0, 0, 4'h0);
    nop(3);
    applyStimulus(0, 0, cmd(CMD_RD), 2, 0, 0, 0, 4'h0);
    checkOutput(0, 0, 4'h0, "halted_act_still_opening");
    applyStimulus(0, 0, cmd(CMD_RD), 2, 0, 0, 0, 4'h0);
    checkOutput(1, 0, 4'h0, "halted_act_open");
    nop(1);

    // Write/read back on bank0 row1.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, cmd(CMD_WR), 0, 1, wcols[i], 1, wvals[i]);
      checkOutput(0, 0, 4'h0, "wr_no_drive");
    end
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, cmd(CMD_RD), 0, 1, wcols[i], 0, 4'h0);
      checkOutput(1, 1, wvals[i], "rd_stream_data");
    end
    applyStimulus(0, 1, '0, 0, 0, 0, 0, 4'h0);
    applyStimulus(0, 1, '0, 0, 0, 0, 0, 4'h0);
    checkOutput(1, 1, 4'd7, "halt_holds_beat");
    nop(1);
    checkOutput(0, 0, 4'h0, "after_halt_release");

    // Precharge bank0: later reads are ignored.
    applyStimulus(0, 0, cmd(CMD_PR), 0, 0, 0, 0, 4'h0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, cmd(CMD_RD), 0, 1, 1, 0, 4'h0);
      checkOutput(0, 0, 4'h0, "rd_after_pr_ignored");
    end

    // Bank1: write 3, close, then WR/RD to idle bank and ACT+WR are ignored.
    applyStimulus(0, 0, cmd(CMD_ACT), 1, 0, 0, 0, 4'h0);
    nop(4);
    applyStimulus(0, 0, cmd(CMD_WR), 1, 0, 5, 1, 4'd3);
    applyStimulus(0, 0, cmd(CMD_PR), 1, 0, 0, 0, 4'h0);
    nop(5);
    applyStimulus(0, 0, cmd(CMD_WR), 1, 0, 5, 1, 4'd15);
    applyStimulus(0, 0, cmd(CMD_RD), 1, 0, 5, 0, 4'h0);
    checkOutput(0, 0, 4'h0, "rd_idle_bank_ignored");
    applyStimulus(0, 0, cmd(CMD_ACT) | cmd(CMD_WR), 1, 0, 5, 1, 4'd12);
    nop(4);
    applyStimulus(0, 0, cmd(CMD_RD), 1, 0, 5, 0, 4'h0);
    checkOutput(1, 1, 4'd3, "idle_and_act_wr_no_store");
    nop(1);

    // WRA closes the bank once no further column command follows.
    applyStimulus(0, 0, cmd(CMD_WRA), 1, 0, 2, 1, 4'd9);
    nop(1);
    applyStimulus(0, 0, cmd(CMD_RD), 1, 0, 2, 0, 4'h0);
    checkOutput(0, 0, 4'h0, "rd_after_wra_ignored");
    nop(4);
    applyStimulus(0, 0, cmd(CMD_ACT), 1, 0, 0, 0, 4'h0);
    nop(4);
    applyStimulus(0, 0, cmd(CMD_RD), 1, 0, 2, 0, 4'h0);
    checkOutput(1, 1, 4'd9, "wra_data_after_reopen");

    // Reset during a read beat aborts it.
    applyStimulus(0, 0, cmd(CMD_RD), 1, 0, 2, 0, 4'h0);
    applyStimulus(1, 0, '0, 0, 0, 0, 0, 4'h0);
    checkOutput(0, 0, 4'h0, "reset_aborts_burst");
    nop(1);

    // Randomized traffic, checked each cycle against the model.
    for (int n = 0; n < 3000; n++) begin
      r    = ($urandom_range(0, 199) == 0);
      h    = ($urandom_range(0, 9) == 0);
      pick = $urandom_range(0, 15);
      c    = '0;
      case (pick)
        0, 1, 2:  c = cmd(CMD_ACT);
        3:        c = cmd(CMD_PR);
        4:        c = ($urandom_range(0, 3) == 0) ? cmd(CMD_PRA) : '0;
        5, 6, 7:  c = cmd(CMD_RD);
        8:        c = cmd(CMD_RDA);
        9, 10, 11: c = cmd(CMD_WR);
        12:       c = cmd(CMD_WRA);
        13:       c = 19'($urandom);
        default:  c = '0;
      endcase
      if (exp_drive) c[1:0] = 2'b00;
      den = |c[1:0];
      applyStimulus(r, h, c, $urandom_range(0, 3), $urandom_range(0, 7),
                    $urandom_range(0, 7), den, 4'($urandom));
    end

    nop(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
